// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the program loader
//
// Signals:
//   rx_data   [7:0]        incoming byte
//   rx_valid               rx_data is valid
//   rx_ready               loader accepts a byte this cycle (transfer on rx_valid && rx_ready)
//   mem_we                 instruction memory write strobe, one cycle per word
//   mem_addr  [ADDR_W-1:0] word write address
//   mem_wdata [15:0]       word write data
// Modports:
//   slave  - the loader (consumes bytes, drives the memory write port)
//   master - the byte source / memory side
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader: framed byte stream -> 16-bit instruction words, checksum, cpu_run
//
// Frame: HDR, CNT_HI, CNT_LO, count words (high byte first), CKSUM.
// CKSUM is the mod-256 sum of CNT_HI, CNT_LO and every data byte.
//
// Ports:
//   clk      system clock, rising edge
//   nClear   synchronous active-low reset
//   bus      imem_loader_if.slave: rx_data/rx_valid/rx_ready byte stream in,
//            mem_we/mem_addr/mem_wdata instruction memory write port out
//   busy     a frame is in progress (CNT_HI .. CKSUM)
//   err      last frame failed (bad checksum or count > DEPTH)
//   cpu_run  verified image in memory; drives the MCU's nClear
module imem_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic          clk,
    input  logic          nClear,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          err,
    output logic          cpu_run
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CKSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [15:0]       count_q;
    logic [15:0]       word_cnt;
    logic [7:0]        sum_q;
    logic [7:0]        hi_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;

    logic              accept;
    logic [15:0]       count_in;
    logic              over_depth;
    logic              last_word;

    assign accept     = bus.rx_valid && bus.rx_ready;
    // Full count as it will be latched when CNT_LO is accepted.
    assign count_in   = {count_q[15:8], bus.rx_data};
    // With ADDR_W = 16 every 16-bit count fits, so the check drops out.
    assign over_depth = (ADDR_W < 16) && ({1'b0, count_in} > DEPTH_17);
    assign last_word  = (word_cnt + 16'd1) == count_q;

    always_ff @(posedge clk) begin
        if (!nClear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_IDLE:    if (bus.rx_data == HDR) state_nxt = S_CNT_HI;
                S_CNT_HI:  state_nxt = S_CNT_LO;
                S_CNT_LO: begin
                    if (over_depth)             state_nxt = S_ERROR;
                    else if (count_in == 16'd0) state_nxt = S_CKSUM;
                    else                        state_nxt = S_DATA_HI;
                end
                S_DATA_HI: state_nxt = S_DATA_LO;
                S_DATA_LO: state_nxt = last_word ? S_CKSUM : S_DATA_HI;
                S_CKSUM:   state_nxt = (bus.rx_data == sum_q) ? S_RUN : S_ERROR;
                S_RUN:     state_nxt = S_RUN;
                S_ERROR:   if (bus.rx_data == HDR) state_nxt = S_CNT_HI;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nClear) begin
            count_q     <= '0;
            word_cnt    <= '0;
            sum_q       <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (bus.rx_data == HDR) begin
                            sum_q    <= '0;
                            word_cnt <= '0;
                        end
                    end
                    S_CNT_HI: begin
                        count_q[15:8] <= bus.rx_data;
                        sum_q         <= sum_q + bus.rx_data;
                    end
                    S_CNT_LO: begin
                        count_q[7:0] <= bus.rx_data;
                        sum_q        <= sum_q + bus.rx_data;
                        word_cnt     <= '0;
                    end
                    S_DATA_HI: begin
                        hi_q  <= bus.rx_data;
                        sum_q <= sum_q + bus.rx_data;
                    end
                    S_DATA_LO: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_cnt[ADDR_W-1:0];
                        mem_wdata_q <= {hi_q, bus.rx_data};
                        sum_q       <= sum_q + bus.rx_data;
                        word_cnt    <= word_cnt + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    // Gated by nClear so no byte is taken while reset is held.
    assign bus.rx_ready  = nClear && (state != S_RUN);

    assign busy    = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_DATA_HI)
                  || (state == S_DATA_LO) || (state == S_CKSUM);
    assign err     = (state == S_ERROR);
    assign cpu_run = (state == S_RUN);
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a frame-parsing reference model
module tb_imem_loader;
    localparam int         AW    = 4;
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] HDR   = 8'hA5;

    logic clk = 1'b0;
    logic nClear;
    logic busy;
    logic err;
    logic cpu_run;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .HDR(HDR)) dut (
        .clk     (clk),
        .nClear  (nClear),
        .bus     (bus),
        .busy    (busy),
        .err     (err),
        .cpu_run (cpu_run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]      stim[$];
    logic [AW+15:0]  got[$];
    logic [AW+15:0]  exp_w[$];
    logic [7:0]      good_frame[10];
    int              m_nacc;
    bit              m_run;
    bit              m_err;
    bit              m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    // Capture every write strobe away from the active edge.
    always @(negedge clk) begin
        if (nClear === 1'b1 && bus.mem_we === 1'b1)
            got.push_back({bus.mem_addr, bus.mem_wdata});
    end

    // Reference: parse the byte list as frames. Produces the expected writes,
    // final err/cpu_run/busy and how many bytes are consumed before the loader
    // stops accepting (after a verified checksum).
    task automatic ref_model();
        int         n;
        int         i;
        int         cnt;
        bit         partial;
        logic [7:0] sum;
        n = stim.size();
        i = 0;
        m_run = 0; m_err = 0; m_busy = 0;
        exp_w.delete();
        while (i < n && !m_run) begin
            if (stim[i] != HDR) begin
                i++;
                continue;
            end
            m_err  = 0;
            m_busy = 1;
            i++;
            if (i + 2 > n) begin
                i = n;
                break;
            end
            cnt = {stim[i], stim[i+1]};
            sum = stim[i] + stim[i+1];
            i += 2;
            if (cnt > DEPTH) begin
                m_err  = 1;
                m_busy = 0;
                continue;
            end
            partial = 0;
            for (int k = 0; k < cnt; k++) begin
                if (i + 2 > n) begin
                    partial = 1;
                    break;
                end
                exp_w.push_back({AW'(k), stim[i], stim[i+1]});
                sum = sum + stim[i] + stim[i+1];
                i += 2;
            end
            if (partial || i >= n) begin
                i = n;
                break;
            end
            m_busy = 0;
            if (stim[i] == sum) m_run = 1;
            else                m_err = 1;
            i++;
        end
        m_nacc = m_run ? i : n;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int budget;
        if (gap) begin
            bus.rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        budget = 0;
        while (bus.rx_ready !== 1'b1 && budget < 8) begin
            @(posedge clk); #1;
            budget++;
        end
        if (bus.rx_ready !== 1'b1) check("accept_timeout", 32'(bus.rx_ready), 1);
        else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        nClear       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        got.delete();
        nClear = 1'b1;
        #1;
    endtask

    task automatic load_good();
        stim.delete();
        foreach (good_frame[k]) stim.push_back(good_frame[k]);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_nwr"}, got.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < got.size(); k++)
            check({tag, "_wr"}, got[k], exp_w[k]);
        check({tag, "_err"}, err, m_err);
        check({tag, "_run"}, cpu_run, m_run);
        check({tag, "_busy"}, busy, m_busy);
        check({tag, "_rdy"}, bus.rx_ready, !m_run);
    endtask

    // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic run_stim(input int mode, input string tag);
        bit gap;
        ref_model();
        for (int i = 0; i < m_nacc; i++) begin
            gap = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_byte(stim[i], gap);
        end
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic check_good_writes(input string tag);
        check({tag, "_n"}, got.size(), 3);
        if (got.size() >= 3) begin
            check({tag, "_w0"}, got[0], {4'd0, 16'h1234});
            check({tag, "_w1"}, got[1], {4'd1, 16'h5678});
            check({tag, "_w2"}, got[2], {4'd2, 16'h9ABC});
        end
        check({tag, "_run"}, cpu_run, 1);
        check({tag, "_rdy"}, bus.rx_ready, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int         nfr;
        int         ng;
        int         cnt;
        logic [7:0] s;
        logic [7:0] b;

        good_frame = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h6D};
        nClear       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        nClear = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_run", cpu_run, 0);
        check("rst_rdy", bus.rx_ready, 0);
        got.delete();
        nClear = 1'b1;
        #1;
        check("rel_rdy", bus.rx_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_run", cpu_run, 0);

        // Good load, back-to-back
        load_good();
        run_stim(0, "good");
        check_good_writes("good_c");

        // Bad checksum, then recovery without reset
        do_reset();
        load_good();
        stim[9] = 8'h6E;
        run_stim(0, "badck");
        check("badck_err", err, 1);
        check("badck_run", cpu_run, 0);
        got.delete();
        send_byte(8'hA5, 1'b0);
        check("recov_err_clr", err, 0);
        check("recov_busy", busy, 1);
        for (int i = 1; i < 10; i++) send_byte(good_frame[i], 1'b0);
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_good_writes("recov");

        // Garbage then toggling valid
        do_reset();
        load_good();
        stim.push_front(8'h5A);
        stim.push_front(8'hFF);
        stim.push_front(8'h00);
        run_stim(1, "garb");
        check_good_writes("garb_c");

        // Oversize count
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        check("over_err", err, 1);
        check("over_busy", busy, 0);
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("over_nwr", got.size(), 0);
        stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_stim(0, "zero");
        check("zero_run", cpu_run, 1);
        check("zero_nwr", got.size(), 0);

        // Mid-frame reset after byte 56
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(good_frame[i], 1'b0);
        bus.rx_valid = 1'b0;
        nClear = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", busy, 0);
        check("mid_rdy", bus.rx_ready, 0);
        nClear = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_nwr", got.size(), 1);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_rdy", bus.rx_ready, 1);
        got.delete();
        load_good();
        run_stim(0, "mid_reload");
        check_good_writes("mid_c");

        // Randomized frames: garbage, odd counts, bad sums, truncation, gaps
        for (int t = 0; t < 40; t++) begin
            do_reset();
            stim.delete();
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                ng = $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) stim.push_back(8'($urandom));
                stim.push_back(HDR);
                cnt = $urandom_range(0, 18);
                stim.push_back(8'(cnt >> 8));
                stim.push_back(8'(cnt));
                s = 8'(cnt >> 8) + 8'(cnt);
                if (cnt <= DEPTH) begin
                    for (int k = 0; k < 2 * cnt; k++) begin
                        b = 8'($urandom);
                        stim.push_back(b);
                        s = s + b;
                    end
                end
                stim.push_back(($urandom_range(0, 3) == 0) ? s + 8'd1 : s);
            end
            if ($urandom_range(0, 4) == 0) begin
                ng = $urandom_range(1, 3);
                for (int g = 0; g < ng; g++) void'(stim.pop_back());
            end
            run_stim($urandom_range(0, 2), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
